// File: rtl/risc_pkg.sv
// Shared definitions for the multicycle RISC core: default widths and the
// LM/SM sequencer state encoding.
package risc_pkg;

  localparam int ADDR_W_DEF = 16;
  localparam int DATA_W_DEF = 16;
  localparam int NREG_DEF   = 8;
  localparam int REG_IDX_W  = $clog2(NREG_DEF);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WB    = 2'd2,
    DONE  = 2'd3
  } lmsm_state_t;

endpackage

// File: rtl/lsb_prio_enc.sv
// Lowest-set-bit finder: idx is the position of the least significant 1 in
// vec, any flags that at least one bit is set (idx reads 0 when none is).
module lsb_prio_enc #(
  parameter int NREG  = 8,
  parameter int IDX_W = $clog2(NREG)
) (
  input  logic [NREG-1:0]  vec,
  output logic [IDX_W-1:0] idx,
  output logic             any
);

  // Scan from the top down so the lowest set bit is the last one to win.
  always_comb begin
    idx = '0;
    for (int i = NREG - 1; i >= 0; i--) begin
      idx = vec[i] ? IDX_W'(i) : idx;
    end
    any = |vec;
  end

endmodule

// File: rtl/lmsm_sequencer.sv
// Load-Multiple / Store-Multiple sequencer. Walks the set bits of a latched
// register list in ascending order, one memory transfer per register, and
// writes loaded data back to the register file in a separate WB cycle.
module lmsm_sequencer
  import risc_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF,
  parameter int NREG   = NREG_DEF
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    start,
  input  logic                    is_store,
  input  logic [ADDR_W-1:0]       base_addr,
  input  logic [NREG-1:0]         reg_list,
  output logic                    busy,
  output logic                    done,
  output logic                    mem_req,
  output logic                    mem_we,
  output logic [ADDR_W-1:0]       mem_addr,
  output logic [DATA_W-1:0]       mem_wdata,
  input  logic                    mem_ack,
  input  logic [DATA_W-1:0]       mem_rdata,
  output logic [$clog2(NREG)-1:0] rf_raddr,
  input  logic [DATA_W-1:0]       rf_rdata,
  output logic                    rf_we,
  output logic [$clog2(NREG)-1:0] rf_waddr,
  output logic [DATA_W-1:0]       rf_wdata
);

  localparam int IDX_W = $clog2(NREG);

  lmsm_state_t       state_r, state_next_s;
  logic [NREG-1:0]   mask_r, mask_next_s, mask_clr_s;
  logic [ADDR_W-1:0] addr_r, addr_next_s;
  logic              is_store_r, is_store_next_s;
  logic              left_s;
  logic [IDX_W-1:0]  idx_s;
  logic              any_s;

  logic              busy_r, done_r, mem_req_r, mem_we_r, rf_we_r;
  logic [ADDR_W-1:0] mem_addr_r;
  logic [IDX_W-1:0]  rf_raddr_r, rf_waddr_r;
  logic [DATA_W-1:0] rf_wdata_r, mem_wdata_s;
  logic              rf_we_next_s;
  logic [IDX_W-1:0]  rf_waddr_next_s;
  logic [DATA_W-1:0] rf_wdata_next_s;

  // rf_raddr_r always holds the register being transferred while in ISSUE.
  assign mask_clr_s = mask_r & ~(NREG'(1) << rf_raddr_r);
  assign left_s     = |mask_clr_s;

  // Next register is picked from the mask the sequencer is about to hold.
  lsb_prio_enc #(
    .NREG  (NREG),
    .IDX_W (IDX_W)
  ) u_prio_enc (
    .vec (mask_next_s),
    .idx (idx_s),
    .any (any_s)
  );

  // Next-state and next-output decode for the transfer loop.
  always_comb begin
    state_next_s    = state_r;
    mask_next_s     = mask_r;
    addr_next_s     = addr_r;
    is_store_next_s = is_store_r;
    rf_we_next_s    = 1'b0;
    rf_waddr_next_s = '0;
    rf_wdata_next_s = '0;
    case (state_r)
      IDLE: begin
        if (start) begin
          is_store_next_s = is_store;
          addr_next_s     = base_addr;
          mask_next_s     = reg_list;
          state_next_s    = (|reg_list) ? ISSUE : DONE;
        end else begin
          state_next_s = IDLE;
        end
      end
      ISSUE: begin
        if (mem_ack) begin
          mask_next_s = mask_clr_s;
          addr_next_s = addr_r + ADDR_W'(1);
          if (is_store_r) begin
            state_next_s = left_s ? ISSUE : DONE;
          end else begin
            state_next_s    = WB;
            rf_we_next_s    = 1'b1;
            rf_waddr_next_s = rf_raddr_r;
            rf_wdata_next_s = mem_rdata;
          end
        end else begin
          state_next_s = ISSUE;
        end
      end
      WB:      state_next_s = (|mask_r) ? ISSUE : DONE;
      DONE:    state_next_s = IDLE;
      default: state_next_s = IDLE;
    endcase
  end

  // State, working registers and registered outputs; reset aborts everything.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r    <= IDLE;
      mask_r     <= '0;
      addr_r     <= '0;
      is_store_r <= 1'b0;
      busy_r     <= 1'b0;
      done_r     <= 1'b0;
      mem_req_r  <= 1'b0;
      mem_we_r   <= 1'b0;
      mem_addr_r <= '0;
      rf_raddr_r <= '0;
      rf_we_r    <= 1'b0;
      rf_waddr_r <= '0;
      rf_wdata_r <= '0;
    end else begin
      state_r    <= state_next_s;
      mask_r     <= mask_next_s;
      addr_r     <= addr_next_s;
      is_store_r <= is_store_next_s;
      busy_r     <= (state_next_s != IDLE);
      done_r     <= (state_next_s == DONE);
      mem_req_r  <= (state_next_s == ISSUE);
      mem_we_r   <= (state_next_s == ISSUE) && is_store_next_s;
      mem_addr_r <= (state_next_s == ISSUE) ? addr_next_s : '0;
      rf_raddr_r <= ((state_next_s == ISSUE) && any_s) ? idx_s : '0;
      rf_we_r    <= rf_we_next_s;
      rf_waddr_r <= rf_waddr_next_s;
      rf_wdata_r <= rf_wdata_next_s;
    end
  end

  // Store data comes straight from the combinational-read register file.
  always_comb begin
    if ((state_r == ISSUE) && is_store_r) begin
      mem_wdata_s = rf_rdata;
    end else begin
      mem_wdata_s = '0;
    end
  end

  assign busy      = busy_r;
  assign done      = done_r;
  assign mem_req   = mem_req_r;
  assign mem_we    = mem_we_r;
  assign mem_addr  = mem_addr_r;
  assign mem_wdata = mem_wdata_s;
  assign rf_raddr  = rf_raddr_r;
  assign rf_we     = rf_we_r;
  assign rf_waddr  = rf_waddr_r;
  assign rf_wdata  = rf_wdata_r;

endmodule

// File: tb/tb_lmsm_sequencer.sv
// Self-checking bench for lmsm_sequencer: directed cases plus randomized
// LM/SM operations compared against a transfer-list reference model.
module tb_lmsm_sequencer;

  logic        clk = 1'b0;
  logic        rst_n, start, is_store, busy, done, mem_req, mem_we, mem_ack;
  logic [15:0] base_addr, mem_addr, mem_wdata, mem_rdata, rf_rdata, rf_wdata;
  logic [7:0]  reg_list;
  logic [2:0]  rf_raddr, rf_waddr;
  logic        rf_we;
  logic [15:0] rf_mem [8];

  int err_cnt = 0;
  int chk_cnt = 0;

  always #5 clk = ~clk;

  assign rf_rdata = rf_mem[rf_raddr];

  lmsm_sequencer dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .is_store  (is_store),
    .base_addr (base_addr),
    .reg_list  (reg_list),
    .busy      (busy),
    .done      (done),
    .mem_req   (mem_req),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_ack   (mem_ack),
    .mem_rdata (mem_rdata),
    .rf_raddr  (rf_raddr),
    .rf_rdata  (rf_rdata),
    .rf_we     (rf_we),
    .rf_waddr  (rf_waddr),
    .rf_wdata  (rf_wdata)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    chk_cnt++;
    if (obs !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // All outputs must read zero (reset / idle).
  task automatic chk_all_zero(input string tag);
    chk(tag, {busy, done, mem_req, mem_we, mem_addr, mem_wdata,
              rf_raddr, rf_we, rf_waddr, rf_wdata}, 64'd0);
  endtask

  // One LM/SM operation. wmode<0 picks random ack waits (0..2) per transfer.
  task automatic run_op(input logic st, input logic [15:0] base, input logic [7:0] list,
                        input int wmode, input logic poke);
    int          regs[$];
    int          waits[$];
    logic [15:0] ld_data[$];
    int          k, wcnt, exp_done, nwe, cyc;
    bit          fin;
    logic [15:0] ea;
    for (int i = 0; i < 8; i++) begin
      if (list[i]) begin
        regs.push_back(i);
        waits.push_back(wmode < 0 ? int'($urandom_range(0, 2)) : wmode);
      end
    end
    exp_done = 1;
    foreach (regs[j]) exp_done += 1 + waits[j] + (st ? 0 : 1);

    @(negedge clk);
    start = 1'b1; is_store = st; base_addr = base; reg_list = list; mem_ack = 1'b0;
    @(negedge clk);
    // Scramble the launch inputs to show they were latched.
    start = 1'b0; is_store = ~st; base_addr = 16'($urandom); reg_list = 8'($urandom);
    cyc = 1; k = 0; nwe = 0; fin = 1'b0;
    wcnt = (regs.size() > 0) ? waits[0] : 0;
    while (!fin && cyc < exp_done + 20) begin
      chk("busy", busy, 1'b1);
      if (mem_req) begin
        if (k >= regs.size()) begin
          chk("extra_req", 1'b1, 1'b0);
          mem_ack = 1'b1;
        end else begin
          ea = base + 16'(k);
          chk("mem_addr", mem_addr, ea);
          chk("mem_we", mem_we, st);
          if (st) chk("mem_wdata", mem_wdata, rf_mem[regs[k]]);
          if (wcnt > 0) begin
            mem_ack = 1'b0;
            wcnt--;
          end else begin
            mem_ack = 1'b1;
            mem_rdata = 16'($urandom);
            if (!st) ld_data.push_back(mem_rdata);
            k++;
            wcnt = (k < regs.size()) ? waits[k] : 0;
          end
        end
      end else begin
        mem_ack = 1'($urandom);
        mem_rdata = 16'($urandom);
      end
      if (rf_we) begin
        if (st || nwe >= ld_data.size()) begin
          chk("spurious_rf_we", 1'b1, 1'b0);
        end else begin
          chk("rf_waddr", rf_waddr, regs[nwe]);
          chk("rf_wdata", rf_wdata, ld_data[nwe]);
          rf_mem[rf_waddr] = rf_wdata;
        end
        nwe++;
      end
      if (poke && cyc == 2 && exp_done > 3) begin
        start = 1'b1; reg_list = ~list; is_store = ~st;
      end else begin
        start = 1'b0;
      end
      if (done) begin
        chk("done_cycle", cyc, exp_done);
        fin = 1'b1;
      end else begin
        @(negedge clk);
        cyc++;
      end
    end
    if (!fin) chk("done_timeout", 1'b0, 1'b1);
    mem_ack = 1'b0;
    start = 1'b0;
    chk("xfer_count", k, regs.size());
    chk("rf_we_count", nwe, st ? 0 : regs.size());
    @(negedge clk);
    chk("idle_busy", busy, 1'b0);
    chk("idle_done", done, 1'b0);
    chk("idle_req", mem_req, 1'b0);
  endtask

  initial begin
    int seen;
    rst_n = 1'b0; start = 1'b0; is_store = 1'b0; base_addr = 16'h0000;
    reg_list = 8'h00; mem_ack = 1'b0; mem_rdata = 16'h0000;
    for (int i = 0; i < 8; i++) rf_mem[i] = 16'($urandom);
    @(negedge clk);
    @(negedge clk);
    chk_all_zero("reset_outputs");
    rst_n = 1'b1;
    @(negedge clk);
    chk_all_zero("idle_outputs");

    // Directed cases.
    rf_mem[0] = 16'h1111; rf_mem[2] = 16'h2222;
    run_op(1'b1, 16'h0040, 8'h05, 0, 1'b0);
    run_op(1'b0, 16'h0100, 8'h81, 2, 1'b0);
    run_op(1'b1, 16'h1234, 8'h00, 0, 1'b0);
    run_op(1'b0, 16'h1234, 8'h00, 0, 1'b0);
    run_op(1'b1, 16'hFFFF, 8'h03, 0, 1'b0);
    run_op(1'b0, 16'hFFFE, 8'hE0, -1, 1'b0);
    run_op(1'b0, 16'h0200, 8'h0F, 1, 1'b1);
    run_op(1'b1, 16'h0300, 8'h3C, 0, 1'b1);

    // Reset during WB of an 8-register load.
    @(negedge clk);
    start = 1'b1; is_store = 1'b0; base_addr = 16'h0400; reg_list = 8'hFF;
    @(negedge clk);
    start = 1'b0; mem_ack = 1'b1; mem_rdata = 16'($urandom);
    seen = 0;
    for (int c = 0; c < 40 && seen < 3; c++) begin
      if (rf_we) seen++;
      if (seen < 3) @(negedge clk);
    end
    chk("wb_reached", seen, 3);
    rst_n = 1'b0;
    @(negedge clk);
    chk_all_zero("abort_outputs");
    rst_n = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      chk("post_abort_rf_we", rf_we, 1'b0);
      chk("post_abort_done", done, 1'b0);
      chk("post_abort_busy", busy, 1'b0);
    end
    mem_ack = 1'b0;
    run_op(1'b1, 16'h0500, 8'hFF, 0, 1'b0);

    // Randomized operations.
    for (int n = 0; n < 30; n++) begin
      run_op(1'($urandom), 16'($urandom), 8'($urandom), -1, 1'($urandom));
    end

    $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
    $finish;
  end

endmodule
